// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV64 pipeline definitions used by fetch, decode and immediate
// generation: address width, canonical NOP, control-transfer opcodes and the
// fetch buffer entry type.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

    // Sequential next-word address; wraps naturally modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock in-order FIFO with synchronous flush and occupancy count.
// Head data is read straight from the storage registers (no bypass, so a
// push becomes visible one cycle later). Flush takes priority over push/pop.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   i_flush            clear pointers and count
//   i_push, i_wdata    write one entry (caller guarantees not full)
//   i_pop              consume head (ignored when empty)
//   o_rdata            head entry
//   o_empty            no entries
//   o_count            occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; a push+pop on a full FIFO overwrites the slot being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// RV64 instruction-fetch stage. Owns the PC, issues word requests to
// instruction memory under a credit limit (buffered + outstanding <=
// FIFO_DEPTH), buffers in-order responses with their PCs and hands them to
// decode on a valid/ready handshake. An EX redirect flushes the buffer and
// marks every in-flight response to be dropped.
// Optional build macro: FETCH_MISALIGN_EXC_EN -- a redirect to a non-word-
// aligned target pushes one {target, NOP} entry flagged id_misaligned and
// halts fetch until the next redirect. Without it the target's low two bits
// are forced to zero.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   imem_req/addr/gnt             request channel (sampled on req & gnt)
//   imem_rvalid/rdata             in-order response channel
//   redirect_valid/pc             one-cycle redirect from EX
//   id_valid/ready/inst/pc        decode handshake
//   id_misaligned                 (FETCH_MISALIGN_EXC_EN only) head is a
//                                 misaligned-target marker
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
`ifdef FETCH_MISALIGN_EXC_EN
    output logic            id_misaligned,
`endif
    output logic [XLEN-1:0] id_pc
);

    import riscv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIM = (CW+1)'(FIFO_DEPTH);
`ifdef FETCH_MISALIGN_EXC_EN
    localparam int EW = $bits(fetch_entry_t) + 1;
`else
    localparam int EW = $bits(fetch_entry_t);
`endif

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic [EW-1:0]   w_head_raw;
    logic [EW-1:0]   w_push_data;
    fetch_entry_t    w_head;
    fetch_entry_t    w_rsp_entry;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_credit_ok;
    logic            w_halt;
    logic            w_grant;
    logic            w_drop_rsp;
    logic            w_rsp_push;
    logic            w_push;
    logic            w_pop;

`ifdef FETCH_MISALIGN_EXC_EN
    logic r_halt;
    logic r_exc_pend;

    assign w_redir_pc  = redirect_pc;
    assign w_halt      = r_halt;
    assign w_push      = w_rsp_push | r_exc_pend;
    // The marker entry reuses resp_pc, which was loaded with the target.
    assign w_push_data = r_exc_pend ? {r_resp_pc, NOP_INST, 1'b1}
                                    : {w_rsp_entry, 1'b0};
    assign w_head      = w_head_raw[EW-1:1];
    assign id_misaligned = ~w_empty & w_head_raw[0];

    // Misaligned-target tracking: halt fetch and queue one marker entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt     <= 1'b0;
            r_exc_pend <= 1'b0;
        end else if (redirect_valid) begin
            r_halt     <= (redirect_pc[1:0] != 2'b00);
            r_exc_pend <= (redirect_pc[1:0] != 2'b00);
        end else begin
            r_halt     <= r_halt;
            r_exc_pend <= 1'b0;
        end
    end
`else
    assign w_redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_halt      = 1'b0;
    assign w_push      = w_rsp_push;
    assign w_push_data = w_rsp_entry;
    assign w_head      = w_head_raw;
`endif

    assign w_rsp_entry = '{pc: r_resp_pc, inst: imem_rdata};

    // Outstanding includes responses already marked for dropping.
    assign w_credit_ok = ({1'b0, w_count} + {1'b0, r_outstanding}) < CREDIT_LIM;
    assign imem_req    = rst_n & ~redirect_valid & ~w_halt & w_credit_ok;
    assign imem_addr   = r_pc;
    assign w_grant     = imem_req & imem_gnt;
    assign w_drop_rsp  = imem_rvalid & (r_drop != {CW{1'b0}});
    assign w_rsp_push  = imem_rvalid & ~w_drop_rsp & ~redirect_valid;

    assign id_valid = ~w_empty & ~redirect_valid;
    assign w_pop    = id_valid & id_ready;
    assign id_inst  = w_empty ? NOP_INST : w_head.inst;
    assign id_pc    = w_empty ? {XLEN{1'b0}} : w_head.pc;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_head_raw),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Request PC and response PC tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc      <= w_redir_pc;
            r_resp_pc <= w_redir_pc;
        end else begin
            r_pc      <= w_grant    ? pc_next(r_pc)      : r_pc;
            r_resp_pc <= w_rsp_push ? pc_next(r_resp_pc) : r_resp_pc;
        end
    end

    // In-flight accounting; on redirect every still-pending response becomes a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= {CW{1'b0}};
            r_drop        <= {CW{1'b0}};
        end else if (redirect_valid) begin
            r_outstanding <= r_outstanding - CW'(imem_rvalid);
            r_drop        <= r_outstanding - CW'(imem_rvalid);
        end else begin
            case ({w_grant, imem_rvalid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            r_drop <= w_drop_rsp ? (r_drop - CW'(1)) : r_drop;
        end
    end

endmodule
